subword_store_unit: RTL and testbench

- Read-modify-write engine for MIPS SB/SH/SW stores toward the word-addressed data memory port. It is the narrowing/insert counterpart of the datapath's immediate/load extension path.
- Takes a 32-bit register value and a size, inserts the low byte/half into the correct lane of the existing memory word, and writes the word back.
- Sits between the memory stage and the dcache/RAM data port, and stalls the pipeline via busy.

---
 rtl/subword_pkg.sv | 31 +++
 rtl/byte_lane_merge.sv | 30 +++
 rtl/subword_store_unit.sv | 94 +++++++++
 tb/tb_subword_store_unit.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/subword_pkg.sv
// Shared types and helpers for the sub-word store read-modify-write engine.
package subword_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } sws_state_t;

  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;
  localparam int LANE_W = 2;

  // Size encoding 3 has no legal access, so it is always rejected.
  function automatic logic is_misaligned(input mem_size_t size, input logic [LANE_W-1:0] lane);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = lane[0];
      SZ_WORD: is_misaligned = (lane != 2'b00);
      default: is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// Inserts the low byte/half of wdata into the addressed lane of an existing word.
module byte_lane_merge
  import subword_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic [31:0]       old_word,
  input  logic [31:0]       wdata,
  input  mem_size_t         size,
  input  logic [LANE_W-1:0] lane,
  output logic [31:0]       merged
);

  logic [1:0] byte_sel;
  logic       half_sel;

  // Big-endian puts lane 0 in the most significant byte, so the lane index is mirrored.
  assign byte_sel = BIG_ENDIAN ? ~lane : lane;
  assign half_sel = BIG_ENDIAN ? ~lane[1] : lane[1];

  always_comb begin
    merged = old_word;
    case (size)
      SZ_BYTE: merged[{byte_sel, 3'b000} +: BYTE_W] = wdata[BYTE_W-1:0];
      SZ_HALF: merged[{half_sel, 4'b0000} +: HALF_W] = wdata[HALF_W-1:0];
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/subword_store_unit.sv
// SB/SH/SW store engine: reads the target word when needed, merges the new lane, writes it back.
module subword_store_unit
  import subword_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              req,
  input  mem_size_t         size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              misaligned,
  output logic              dREN,
  output logic              dWEN,
  output logic [ADDR_W-1:0] daddr,
  output logic [31:0]       dstore,
  input  logic [31:0]       dload,
  input  logic              dwait,
  output sws_state_t        state
);

  sws_state_t        state_next;
  mem_size_t         size_q;
  logic [LANE_W-1:0] lane_q;
  logic [31:0]       wdata_q;
  logic              mis_q;
  logic              req_mis;
  logic [31:0]       merged;

  assign req_mis = is_misaligned(size, addr[LANE_W-1:0]);

  byte_lane_merge #(
    .BIG_ENDIAN(BIG_ENDIAN)
  ) u_merge (
    .old_word(dload),
    .wdata   (wdata_q),
    .size    (size_q),
    .lane    (lane_q),
    .merged  (merged)
  );

  // Memory handshake: dREN/dWEN and daddr/dstore stay constant while dwait is
  // high; a transfer completes on the first rising edge that sees dwait low.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req) begin
          if (req_mis)              state_next = DONE;
          else if (size == SZ_WORD) state_next = WRITE;
          else                      state_next = READ;
        end
      end
      READ:    if (!dwait) state_next = WRITE;
      WRITE:   if (!dwait) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      size_q  <= SZ_BYTE;
      lane_q  <= '0;
      wdata_q <= '0;
      mis_q   <= 1'b0;
      daddr   <= '0;
      dstore  <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && req) begin
        size_q  <= size;
        lane_q  <= addr[LANE_W-1:0];
        wdata_q <= wdata;
        mis_q   <= req_mis;
        daddr   <= {addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
        if (size == SZ_WORD && !req_mis) dstore <= wdata;
      end
      // The merge happens on the read data, so dstore already holds the final word in WRITE.
      if (state == READ && !dwait) dstore <= merged;
    end
  end

  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign misaligned = (state == DONE) && mis_q;
  assign dREN       = (state == READ);
  assign dWEN       = (state == WRITE);

endmodule

// File: tb/tb_subword_store_unit.sv
// Directed plus randomized bench for subword_store_unit against a lane-arithmetic reference model.
module tb_subword_store_unit;
  import subword_pkg::*;

  localparam int W   = 69;
  localparam bit BIG = 1'b1;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        req;
  mem_size_t   size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy, done, misaligned, dREN, dWEN;
  logic [31:0] daddr, dstore;
  logic [31:0] dload;
  logic        dwait;
  sws_state_t  state;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];
  bit           dw_q[$];

  subword_store_unit #(.ADDR_W(32), .BIG_ENDIAN(BIG)) dut (
    .CLK(CLK), .nRST(nRST), .req(req), .size(size), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .misaligned(misaligned), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore), .dload(dload), .dwait(dwait), .state(state)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] ctrl_now();
    return {busy, done, misaligned, dREN, dWEN};
  endfunction

  function automatic bit ref_misaligned(input mem_size_t sz, input logic [31:0] a);
    if (int'(sz) == 3) return 1'b1;
    if (sz == SZ_HALF && (a % 2) != 0) return 1'b1;
    if (sz == SZ_WORD && (a % 4) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_merge(input mem_size_t sz, input logic [31:0] a,
                                            input logic [31:0] w, input logic [31:0] old);
    int unsigned off = a % 4;
    int unsigned sh;
    logic [31:0] mask;
    if (sz == SZ_WORD) return w;
    if (sz == SZ_BYTE) begin
      sh   = BIG ? (3 - off) * 8 : off * 8;
      mask = 32'h0000_00ff << sh;
    end else begin
      sh   = BIG ? (1 - off / 2) * 16 : (off / 2) * 16;
      mask = 32'h0000_ffff << sh;
    end
    return (old & ~mask) | ((w << sh) & mask);
  endfunction

  task automatic junk_inputs();
    addr  = $urandom;
    wdata = $urandom;
    size  = mem_size_t'(2'($urandom_range(0, 3)));
  endtask

  // One store: idle check, acceptance edge, then one check per busy cycle.
  task automatic run_store(input mem_size_t sz, input logic [31:0] a, input logic [31:0] w,
                           input logic [31:0] old, input int rw, input int ww,
                           input bit keep_req, input bit abort);
    logic [31:0] ea = a & ~32'h3;
    logic [31:0] ed = ref_merge(sz, a, w, old);
    logic [W-1:0] e;
    bit d;
    if (ref_misaligned(sz, a)) begin
      exp_q.push_back({5'b11100, ea, ed}); dw_q.push_back(1'b0);
    end else begin
      if (sz != SZ_WORD) begin
        for (int i = 0; i < rw; i++) begin
          exp_q.push_back({5'b10010, ea, ed}); dw_q.push_back(1'b1);
        end
        exp_q.push_back({5'b10010, ea, ed}); dw_q.push_back(1'b0);
      end
      for (int i = 0; i < ww; i++) begin
        exp_q.push_back({5'b10001, ea, ed}); dw_q.push_back(1'b1);
      end
      exp_q.push_back({5'b10001, ea, ed}); dw_q.push_back(1'b0);
      exp_q.push_back({5'b11000, ea, ed}); dw_q.push_back(1'b0);
    end
    req = 1'b1; size = sz; addr = a; wdata = w; dwait = 1'b0; dload = $urandom;
    @(negedge CLK);
    check("idle_ctrl", 32'(ctrl_now()), 32'd0);
    check("idle_state", 32'(state), 32'(IDLE));
    @(posedge CLK); #1;
    if (!keep_req) req = 1'b0;
    junk_inputs();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      d = dw_q.pop_front();
      dwait = d;
      dload = d ? $urandom : old;
      @(negedge CLK);
      check("ctrl", 32'(ctrl_now()), 32'(e[68:64]));
      if (e[65] || e[64]) check("daddr", daddr, e[63:32]);
      if (e[64]) check("dstore", dstore, e[31:0]);
      if (abort && e[64]) begin
        nRST = 1'b0;
        #1;
        check("abort_ctrl", 32'(ctrl_now()), 32'd0);
        check("abort_daddr", daddr, 32'd0);
        check("abort_dstore", dstore, 32'd0);
        check("abort_state", 32'(state), 32'(IDLE));
        #2 nRST = 1'b1;
        exp_q.delete();
        dw_q.delete();
        dwait = 1'b0;
      end
      @(posedge CLK); #1;
      junk_inputs();
    end
  endtask

  initial begin
    mem_size_t sz;
    logic [31:0] a;
    nRST = 1'b0; req = 1'b0; size = SZ_BYTE; addr = '0; wdata = '0;
    dload = '0; dwait = 1'b0;
    #1;
    check("rst_ctrl", 32'(ctrl_now()), 32'd0);
    check("rst_daddr", daddr, 32'd0);
    check("rst_dstore", dstore, 32'd0);
    check("rst_state", 32'(state), 32'(IDLE));
    repeat (2) @(posedge CLK);
    @(negedge CLK) nRST = 1'b1;
    @(posedge CLK); #1;

    run_store(SZ_BYTE, 32'h103, 32'h0000_00ab, 32'h1122_3344, 0, 0, 1'b0, 1'b0);
    run_store(SZ_HALF, 32'h202, 32'h0000_cafe, 32'hdead_beef, 3, 2, 1'b0, 1'b0);
    run_store(SZ_WORD, 32'h040, 32'h1234_5678, 32'h0, 0, 0, 1'b0, 1'b0);
    run_store(SZ_HALF, 32'h301, 32'h0000_5555, 32'h0, 0, 0, 1'b0, 1'b0);
    run_store(SZ_BYTE, 32'h0a1, 32'h0000_0077, 32'h8899_aabb, 0, 3, 1'b0, 1'b1);
    run_store(SZ_BYTE, 32'h0a1, 32'h0000_0077, 32'h8899_aabb, 0, 0, 1'b0, 1'b0);

    // req held high across back-to-back SB/SW pairs
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0)
        run_store(SZ_BYTE, 32'h500 + 32'(i), 32'($urandom), $urandom, 0, 0, 1'b1, 1'b0);
      else
        run_store(SZ_WORD, 32'h600 + 32'(4 * i), $urandom, $urandom, 0, 0, i != 3, 1'b0);
    end

    for (int i = 0; i < 40; i++) begin
      sz = mem_size_t'(2'($urandom_range(0, 3)));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == SZ_WORD) a[1:0] = 2'b00;
        if (sz == SZ_HALF) a[0] = 1'b0;
      end
      run_store(sz, a, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                1'(($urandom_range(0, 1))), 1'b0);
    end
    req = 1'b0;
    @(negedge CLK);
    check("final_idle", 32'(ctrl_now()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
